svpwm_reference_generator: RTL and testbench

SVPWM_REFERENCE_GENERATOR -- requirements
Module: svpwm_reference_generator

---
 rtl/svpwm_reference_generator.sv | 182 ++++++++++++++++++
 tb/tb_svpwm_reference_generator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/svpwm_reference_generator.sv
// rtl/svpwm_reference_generator.sv - SVPWM sector and adjacent-vector dwell-time generator
// One sample per TAST_PERIOD: ROM lookup, two serial 16-cycle multiplies, then publish and phase advance.
module svpwm_reference_generator #(
    parameter int F_CLK   = 100000000,
    parameter int F_TAST  = 5000,
    parameter int AMP_MAX = 17320
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        DIR,
    input  logic [15:0] FREQ_STEP,
    input  logic [14:0] AMPLITUDE,
    output logic [2:0]  SECTOR,
    output logic [14:0] T_LOW,
    output logic [14:0] T_HIGH,
    output logic        VALID,
    output logic        BUSY
);

    localparam int          TAST_PERIOD = F_CLK / F_TAST;
    localparam int          CNT_W       = (TAST_PERIOD > 2) ? $clog2(TAST_PERIOD) : 1;
    localparam logic [14:0] AMP_LIMIT   = 15'(AMP_MAX);
    localparam longint      PI_Q31      = 64'sd6746518852;

    // Elaboration-time sine table in Q31 fixed point; entry i covers i*60/64 degrees,
    // normalised so that the 60-degree entry saturates at full scale.
    function automatic logic [65*16-1:0] build_rom();
        logic [65*16-1:0] rom;
        longint theta, x2, term, s, s60, q;
        rom = '0;
        s60 = 64'sd1;
        for (int i = 64; i >= 0; i--) begin
            theta = (longint'(i) * PI_Q31) / 64'sd192;
            x2    = (theta * theta) >>> 31;
            term  = theta;
            s     = theta;
            for (int k = 1; k <= 7; k++) begin
                term = ((term * x2) >>> 31) / longint'((2 * k) * (2 * k + 1));
                if (k % 2 == 1) s = s - term;
                else            s = s + term;
            end
            if (i == 64) s60 = s;
            q = ((s <<< 17) + s60) / (64'sd2 * s60);
            if (q > 64'sd65535) q = 64'sd65535;
            rom[i*16 +: 16] = 16'(q);
        end
        return rom;
    endfunction

    localparam logic [65*16-1:0] ROM = build_rom();

    function automatic logic [15:0] rom_word(input logic [6:0] idx);
        return ROM[int'(idx)*16 +: 16];
    endfunction

    typedef enum logic [2:0] {IDLE, LOAD, MUL_LOW, MUL_HIGH, PUBLISH} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] sample_cnt;
    logic             tick;
    logic [15:0]      angle;
    logic [2:0]       sector;
    logic             en_q, dir_q;
    logic [15:0]      step_q;
    logic [14:0]      amp_q;
    logic [15:0]      k_lo, k_hi, k_sel;
    logic [3:0]       bit_cnt;
    logic             mul_last;
    logic [30:0]      prod, prod_next;
    logic [14:0]      t_lo_calc, t_hi_calc;
    logic [6:0]       lo_idx, hi_idx;
    logic [16:0]      angle_fwd, angle_rev;

    assign tick      = (sample_cnt == '0);
    assign BUSY      = (state != IDLE);
    assign mul_last  = (bit_cnt == 4'd15);
    assign hi_idx    = {1'b0, angle[15:10]};
    assign lo_idx    = 7'd64 - hi_idx;
    assign angle_fwd = {1'b0, angle} + {1'b0, step_q};
    assign angle_rev = {1'b0, angle} - {1'b0, step_q};

    // MSB-first shift-add: after 16 steps prod holds amp * k.
    assign k_sel     = (state == MUL_HIGH) ? k_hi : k_lo;
    assign prod_next = {prod[29:0], 1'b0} + (k_sel[~bit_cnt] ? {16'd0, amp_q} : 31'd0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sample_cnt <= '0;
        end else if (sample_cnt == CNT_W'(TAST_PERIOD - 1)) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (tick) state_next = LOAD;
            LOAD:     state_next = MUL_LOW;
            MUL_LOW:  if (mul_last) state_next = MUL_HIGH;
            MUL_HIGH: if (mul_last) state_next = PUBLISH;
            PUBLISH:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            angle     <= '0;
            sector    <= '0;
            en_q      <= 1'b0;
            dir_q     <= 1'b0;
            step_q    <= '0;
            amp_q     <= '0;
            k_lo      <= '0;
            k_hi      <= '0;
            bit_cnt   <= '0;
            prod      <= '0;
            t_lo_calc <= '0;
            t_hi_calc <= '0;
            SECTOR    <= '0;
            T_LOW     <= '0;
            T_HIGH    <= '0;
            VALID     <= 1'b0;
        end else begin
            VALID <= 1'b0;
            case (state)
                LOAD: begin
                    en_q    <= ENABLE;
                    dir_q   <= DIR;
                    step_q  <= FREQ_STEP;
                    amp_q   <= (AMPLITUDE > AMP_LIMIT) ? AMP_LIMIT : AMPLITUDE;
                    k_lo    <= rom_word(lo_idx);
                    k_hi    <= rom_word(hi_idx);
                    bit_cnt <= '0;
                    prod    <= '0;
                end
                MUL_LOW: begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (mul_last) begin
                        t_lo_calc <= prod_next[30:16];
                        prod      <= '0;
                    end else begin
                        prod <= prod_next;
                    end
                end
                MUL_HIGH: begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (mul_last) begin
                        t_hi_calc <= prod_next[30:16];
                        prod      <= '0;
                    end else begin
                        prod <= prod_next;
                    end
                end
                PUBLISH: begin
                    VALID  <= 1'b1;
                    SECTOR <= sector;
                    T_LOW  <= en_q ? t_lo_calc : 15'd0;
                    T_HIGH <= en_q ? t_hi_calc : 15'd0;
                    // Published values above use the phase before this advance.
                    if (en_q && !dir_q) begin
                        angle <= angle_fwd[15:0];
                        if (angle_fwd[16]) sector <= (sector == 3'd5) ? 3'd0 : sector + 3'd1;
                    end else if (en_q && dir_q) begin
                        angle <= angle_rev[15:0];
                        if (angle_rev[16]) sector <= (sector == 3'd0) ? 3'd5 : sector - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_svpwm_reference_generator.sv
// tb/tb_svpwm_reference_generator.sv - directed checks of svpwm_reference_generator
// Main instance uses default timing; a fast instance (50-cycle sample) covers long sequences.
module tb_svpwm_reference_generator;

    localparam real PI     = 3.14159265358979323846;
    localparam int  F_AMP  = 43;
    localparam int  F_PER  = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        dir;
    logic [15:0] freq_step;
    logic [14:0] amplitude;

    logic [2:0]  sector, f_sector;
    logic [14:0] t_low, t_high, f_t_low, f_t_high;
    logic        valid, busy, f_valid, f_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    svpwm_reference_generator dut (
        .CLK(clk), .RESET(reset), .ENABLE(enable), .DIR(dir),
        .FREQ_STEP(freq_step), .AMPLITUDE(amplitude),
        .SECTOR(sector), .T_LOW(t_low), .T_HIGH(t_high), .VALID(valid), .BUSY(busy)
    );

    svpwm_reference_generator #(.F_CLK(100000000), .F_TAST(2000000), .AMP_MAX(F_AMP)) dut_fast (
        .CLK(clk), .RESET(reset), .ENABLE(enable), .DIR(dir),
        .FREQ_STEP(freq_step), .AMPLITUDE(amplitude),
        .SECTOR(f_sector), .T_LOW(f_t_low), .T_HIGH(f_t_high), .VALID(f_valid), .BUSY(f_busy)
    );

    typedef struct {
        bit          en;
        bit          dr;
        logic [15:0] step;
        logic [14:0] amp;
        int          n_sample;
        int          exp_sec;
        int          exp_lo;
        int          exp_hi;
    } vec_t;

    vec_t vec[6];

    function automatic int rom_model(input int i);
        real v;
        v = 65536.0 * $sin(real'(i) * PI / 192.0) / $sin(PI / 3.0);
        if (v > 65535.0) return 65535;
        return $rtoi(v + 0.5);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic check_in(input string name, input int actual, input int lo, input int hi);
        n_checks++;
        if (actual >= lo && actual <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected within %0d..%0d", name, actual, lo, hi);
    endtask

    task automatic apply(input bit en, input bit dr, input logic [15:0] step, input logic [14:0] amp);
        enable    = en;
        dir       = dr;
        freq_step = step;
        amplitude = amp;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_valid(input bit fast, input int budget, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            seen = fast ? f_valid : valid;
        end
    endtask

    initial begin
        int  cyc;
        bit  seen;
        int  seq_exp[13];
        int  m_ang, m_sec, idx, e_lo, e_hi, sum, best_sum, best_ang;

        vec[0] = '{1'b1, 1'b0, 16'h0000, 15'd10000, 2, 0, 9999,  0};
        vec[1] = '{1'b1, 1'b0, 16'h0000, 15'd30000, 1, 0, 17319, 0};
        vec[2] = '{1'b0, 1'b0, 16'h1000, 15'd10000, 1, 0, 0,     0};
        vec[3] = '{1'b1, 1'b1, 16'h0001, 15'd10000, 2, 5, 188,   9904};
        vec[4] = '{1'b1, 1'b0, 16'h8000, 15'd10000, 1, 0, 9999,  0};
        vec[5] = '{1'b1, 1'b1, 16'h0001, 15'd40,    1, 0, 39,    0};
        seq_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0};

        reset = 1'b1;
        apply(1'b0, 1'b0, 16'h0000, 15'd0);

        for (int v = 0; v < 6; v++) begin
            apply(vec[v].en, vec[v].dr, vec[v].step, vec[v].amp);
            do_reset();
            @(posedge clk);
            #1;
            check($sformatf("v%0d_busy_after_tick", v), int'(busy), 1);
            wait_valid(1'b0, 40, cyc, seen);
            check($sformatf("v%0d_latency", v), cyc + 1, 35);
            if (vec[v].n_sample == 2) begin
                wait_valid(1'b0, 20010, cyc, seen);
                check($sformatf("v%0d_period", v), cyc, 20000);
            end
            check($sformatf("v%0d_sector", v), int'(sector), vec[v].exp_sec);
            check($sformatf("v%0d_t_low", v), int'(t_low), vec[v].exp_lo);
            check($sformatf("v%0d_t_high", v), int'(t_high), vec[v].exp_hi);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid_strobe", v), int'(valid), 0);
        end

        // Sector sequence at half-sector steps.
        apply(1'b1, 1'b0, 16'h8000, 15'd30000);
        do_reset();
        for (int s = 0; s < 13; s++) begin
            wait_valid(1'b1, F_PER + 10, cyc, seen);
            check($sformatf("seq%0d_seen", s), int'(seen), 1);
            check($sformatf("seq%0d_sector", s), int'(f_sector), seq_exp[s]);
        end

        // Reverse rotation wraps sector 0 -> 5 on the first borrow.
        apply(1'b1, 1'b1, 16'h0001, 15'd40);
        do_reset();
        wait_valid(1'b1, 40, cyc, seen);
        check("rev_first_sector", int'(f_sector), 0);
        wait_valid(1'b1, F_PER + 10, cyc, seen);
        check("rev_second_sector", int'(f_sector), 5);
        check("rev_second_t_high", int'(f_t_high), (40 * rom_model(63)) >>> 16);

        // Disabled: zero dwell, phase and sector frozen.
        apply(1'b0, 1'b0, 16'hC000, 15'd30000);
        do_reset();
        for (int s = 0; s < 3; s++) begin
            wait_valid(1'b1, F_PER + 10, cyc, seen);
            check($sformatf("dis%0d_seen", s), int'(seen), 1);
            check($sformatf("dis%0d_sector", s), int'(f_sector), 0);
            check($sformatf("dis%0d_t_sum", s), int'(f_t_low) + int'(f_t_high), 0);
        end

        // Reset during MUL_HIGH of the second sample aborts it.
        apply(1'b1, 1'b0, 16'h0000, 15'd30000);
        do_reset();
        wait_valid(1'b1, 40, cyc, seen);
        check("abort_first_latency", cyc, 35);
        check("abort_first_t_low", int'(f_t_low), (F_AMP * 65535) >>> 16);
        repeat (35) @(posedge clk);
        #1;
        check("abort_busy_in_mul_high", int'(f_busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", int'(f_valid), 0);
        check("abort_busy", int'(f_busy), 0);
        check("abort_sector", int'(f_sector), 0);
        check("abort_t_low", int'(f_t_low), 0);
        check("abort_t_high", int'(f_t_high), 0);
        reset = 1'b0;
        wait_valid(1'b1, 40, cyc, seen);
        check("abort_restart_latency", cyc, 35);

        // Full sweep against a floating-point ROM model.
        apply(1'b1, 1'b0, 16'h0400, 15'd30000);
        do_reset();
        m_ang    = 0;
        m_sec    = 0;
        best_sum = -1;
        best_ang = 0;
        for (int s = 0; s < 385; s++) begin
            wait_valid(1'b1, F_PER + 10, cyc, seen);
            check($sformatf("sw%0d_seen", s), int'(seen), 1);
            idx  = m_ang >> 10;
            e_lo = (F_AMP * rom_model(64 - idx)) >>> 16;
            e_hi = (F_AMP * rom_model(idx)) >>> 16;
            check($sformatf("sw%0d_sector", s), int'(f_sector), m_sec);
            check($sformatf("sw%0d_t_low", s), int'(f_t_low), e_lo);
            check($sformatf("sw%0d_t_high", s), int'(f_t_high), e_hi);
            sum = int'(f_t_low) + int'(f_t_high);
            check_in($sformatf("sw%0d_t_sum", s), sum, 0, F_PER);
            if (sum > best_sum) begin
                best_sum = sum;
                best_ang = m_ang;
            end
            m_ang += 16'h0400;
            if (m_ang >= 65536) begin
                m_ang -= 65536;
                m_sec = (m_sec == 5) ? 0 : m_sec + 1;
            end
        end
        check_in("sweep_max_angle", best_ang, 16'h5000, 16'hB000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
